// File: rtl/regs_wb_arbiter.sv
// Round-robin write-back arbiter feeding a single register-file write port,
// with a per-register pending-write scoreboard driven by issue-stage marks.
module regs_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      mark_en,
   input  logic [ADDR_W-1:0]         mark_reg,
   output logic [(2**ADDR_W)-1:0]    busy,
   output logic                      write_en,
   output logic [ADDR_W-1:0]         write_reg,
   output logic [DATA_W-1:0]         write_data
);

   localparam int NREG  = 2 ** ADDR_W;
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NREG-1:0]    busy_q, busy_d;
   logic               wen_q, wen_d;
   logic [ADDR_W-1:0]  wreg_q, wreg_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;

   logic [NUM_REQ-1:0] grant_s;
   logic [PTR_W-1:0]   gidx_s;
   logic               found_s;
   logic               xfer_s;
   logic [ADDR_W-1:0]  g_reg_s;
   logic [DATA_W-1:0]  g_data_s;

   // Search for the first valid requester starting at rr_ptr, wrapping around
   always_comb begin
      logic [PTR_W-1:0] idx_v;
      found_s = 1'b0;
      gidx_s  = '0;
      grant_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_v = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found_s && req_valid[idx_v]) begin
            found_s = 1'b1;
            gidx_s  = idx_v;
         end else begin
            found_s = found_s;
         end
      end
      if (rst_n && found_s) begin
         grant_s[gidx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   assign req_ready = grant_s;
   assign xfer_s    = |grant_s;
   assign g_reg_s   = req_reg[gidx_s*ADDR_W +: ADDR_W];
   assign g_data_s  = req_data[gidx_s*DATA_W +: DATA_W];

   // Next-state: pointer advance, write-port capture, scoreboard clear/set
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      wen_d    = 1'b0;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      if (xfer_s) begin
         if (gidx_s == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gidx_s + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         // Register 0 is hardwired: accept the transfer but never write it
         if (g_reg_s != '0) begin
            wen_d          = 1'b1;
            wreg_d         = g_reg_s;
            wdata_d        = g_data_s;
            busy_d[g_reg_s] = 1'b0;
         end else begin
            wen_d = 1'b0;
         end
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      // A same-cycle mark reflects a newer producer, so it overrides the clear
      if (mark_en && (mark_reg != '0)) begin
         busy_d[mark_reg] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         busy_q   <= '0;
         wen_q    <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         wen_q    <= wen_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
      end
   end

   assign busy       = busy_q;
   assign write_en   = wen_q;
   assign write_reg  = wreg_q;
   assign write_data = wdata_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: round-robin order, write-back latency,
// scoreboard mark/clear interplay, register-0 handling and reset behaviour.
module tb_regs_wb_arbiter;

   localparam int NUM_REQ = 3;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;

   logic                      clk;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_reg;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      mark_en;
   logic [ADDR_W-1:0]         mark_reg;
   logic [31:0]               busy;
   logic                      write_en;
   logic [ADDR_W-1:0]         write_reg;
   logic [DATA_W-1:0]         write_data;

   int checks_r;
   int errors_r;

   regs_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_reg    (req_reg),
      .req_data   (req_data),
      .mark_en    (mark_en),
      .mark_reg   (mark_reg),
      .busy       (busy),
      .write_en   (write_en),
      .write_reg  (write_reg),
      .write_data (write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_r++;
      if (obs !== exp) begin
         errors_r++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      req_reg[i*ADDR_W +: ADDR_W] = r;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   initial begin
      checks_r  = 0;
      errors_r  = 0;
      rst_n     = 1'b0;
      req_valid = 3'b111;
      req_reg   = '0;
      req_data  = '0;
      mark_en   = 1'b0;
      mark_reg  = 5'd0;
      set_req(0, 5'd1, 32'hA000_0001);
      set_req(1, 5'd2, 32'hB000_0002);
      set_req(2, 5'd3, 32'hC000_0003);

      // Reset with all requesters valid
      #1;
      chk("rst_ready", 64'(req_ready), 64'h0);
      tick();
      tick();
      chk("rst_ready2", 64'(req_ready), 64'h0);
      chk("rst_wen", 64'(write_en), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_wreg", 64'(write_reg), 64'h0);
      chk("rst_wdata", 64'(write_data), 64'h0);

      // Release: arbitration begins at requester 0, then rotates with no bubbles
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk("rr_ready", 64'(req_ready), 64'(3'b001 << (i % 3)));
         tick();
         chk("rr_wen", 64'(write_en), 64'h1);
         chk("rr_wreg", 64'(write_reg), 64'((i % 3) + 1));
         chk("rr_wdata", 64'(write_data), 64'(req_data[(i % 3)*DATA_W +: DATA_W]));
      end

      // Idle: no grant, write_en drops, write port holds
      req_valid = 3'b000;
      #1;
      chk("idle_ready", 64'(req_ready), 64'h0);
      tick();
      chk("idle_wen", 64'(write_en), 64'h0);
      chk("idle_wreg_hold", 64'(write_reg), 64'd3);
      chk("idle_wdata_hold", 64'(write_data), 64'hC000_0003);

      // Only requester 2 valid, pointer at 0
      set_req(2, 5'd7, 32'hDEAD_BEEF);
      req_valid = 3'b100;
      #1;
      chk("r2_ready", 64'(req_ready), 64'b100);
      tick();
      chk("r2_wen", 64'(write_en), 64'h1);
      chk("r2_wreg", 64'(write_reg), 64'd7);
      chk("r2_wdata", 64'(write_data), 64'hDEAD_BEEF);

      // Pointer back at 0: grant requester 1 moves pointer to 2
      req_valid = 3'b010;
      #1;
      chk("r1_ready", 64'(req_ready), 64'b010);
      tick();
      chk("r1_wreg", 64'(write_reg), 64'd2);
      // From pointer 2 with only 0 and 1 valid, search wraps to 0
      req_valid = 3'b011;
      #1;
      chk("wrap_ready", 64'(req_ready), 64'b001);
      tick();
      chk("wrap_wreg", 64'(write_reg), 64'd1);
      req_valid = 3'b000;

      // Mark reg 5, then write it back
      mark_en  = 1'b1;
      mark_reg = 5'd5;
      tick();
      chk("mark5_busy", 64'(busy), 64'h0000_0020);
      mark_en = 1'b0;
      set_req(0, 5'd5, 32'h0000_0055);
      req_valid = 3'b001;
      #1;
      chk("wb5_ready", 64'(req_ready), 64'b001);
      tick();
      chk("wb5_wen", 64'(write_en), 64'h1);
      chk("wb5_wreg", 64'(write_reg), 64'd5);
      chk("wb5_busy", 64'(busy), 64'h0);
      req_valid = 3'b000;

      // Mark 9, then same-cycle mark and write-back of 9: mark wins
      mark_en  = 1'b1;
      mark_reg = 5'd9;
      tick();
      chk("mark9_busy", 64'(busy), 64'h0000_0200);
      set_req(0, 5'd9, 32'h0000_0099);
      req_valid = 3'b001;
      tick();
      chk("race9_wen", 64'(write_en), 64'h1);
      chk("race9_wreg", 64'(write_reg), 64'd9);
      chk("race9_busy", 64'(busy), 64'h0000_0200);

      // Write-back to reg 0 accepted but suppressed; marking reg 0 ignored
      mark_reg = 5'd0;
      set_req(0, 5'd0, 32'h0000_1234);
      #1;
      chk("r0_ready", 64'(req_ready), 64'b001);
      tick();
      chk("r0_wen", 64'(write_en), 64'h0);
      chk("r0_wreg_hold", 64'(write_reg), 64'd9);
      chk("r0_wdata_hold", 64'(write_data), 64'h0000_0099);
      chk("r0_busy", 64'(busy), 64'h0000_0200);
      mark_en = 1'b0;
      // Pointer advanced past requester 0 despite no write
      req_valid = 3'b111;
      #1;
      chk("r0_ptr_ready", 64'(req_ready), 64'b010);

      // Write to a non-busy register still writes; scoreboard unchanged
      set_req(1, 5'd12, 32'h0000_000C);
      req_valid = 3'b010;
      tick();
      chk("nb_wen", 64'(write_en), 64'h1);
      chk("nb_wreg", 64'(write_reg), 64'd12);
      chk("nb_busy", 64'(busy), 64'h0000_0200);

      // Mid-stream reset drops the in-flight write and clears everything
      set_req(2, 5'd17, 32'h1717_1717);
      req_valid = 3'b111;
      #1;
      chk("pre_rst_ready", 64'(req_ready), 64'b100);
      tick();
      chk("pre_rst_wreg", 64'(write_reg), 64'd17);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'h0);
      tick();
      chk("mid_rst_wen", 64'(write_en), 64'h0);
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_wreg", 64'(write_reg), 64'h0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 64'(req_ready), 64'b001);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule
